// File: rtl/spi_reg_bridge.sv
// SPI mode-0 target that bridges host transactions onto the 5-bit/8-bit register bus.
// Define SPI_REG_BRIDGE_AUTOINC_EN for burst mode (address increments after every data byte).
module spi_reg_bridge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [4:0] reg_addr,
  output logic [7:0] reg_data_out,
  input  logic [7:0] reg_data_in,
  output logic       reg_write
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCmd  = 2'd1;
  localparam logic [1:0] StData = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_prev_q, sclk_rise, sclk_fall;

  logic [1:0] state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] rx_q, tx_q;
  logic       armed_q;
  logic       byte_done_q, byte_cmd_q, wr_q, pref_q;

  // The cs_n chain resets low so a host still holding cs_n low is not mistaken for a fresh frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign miso_oe   = armed_q & ~cs_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_prev_q  <= 1'b0;
      state_q      <= StIdle;
      bit_cnt_q    <= 3'd0;
      rx_q         <= 8'h00;
      tx_q         <= 8'h00;
      armed_q      <= 1'b0;
      byte_done_q  <= 1'b0;
      byte_cmd_q   <= 1'b0;
      wr_q         <= 1'b0;
      pref_q       <= 1'b0;
      miso         <= 1'b0;
      reg_addr     <= 5'd0;
      reg_data_out <= 8'h00;
      reg_write    <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      reg_write   <= 1'b0;
      byte_done_q <= 1'b0;
      if (cs_s) begin
        armed_q <= 1'b1;
      end

      if (state_q == StIdle) begin
        if (armed_q && !cs_s) begin
          state_q   <= StCmd;
          bit_cnt_q <= 3'd0;
          tx_q      <= 8'h00;
          miso      <= 1'b0;
        end
      end else begin
        if (sclk_rise) begin
          rx_q      <= {rx_q[6:0], mosi_s};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_done_q <= 1'b1;
            byte_cmd_q  <= (state_q == StCmd);
            if (state_q == StCmd) begin
              state_q <= StData;
            end
          end
        end
        if (sclk_fall) begin
          miso <= tx_q[7];
          tx_q <= {tx_q[6:0], 1'b0};
        end
        // A byte completing together with cs_n rising still finishes in the pipeline below.
        if (cs_s) begin
          state_q   <= StIdle;
          bit_cnt_q <= 3'd0;
        end
      end

      // Prefetch: reg_data_in is combinational on reg_addr, captured two cycles after a boundary.
      if (pref_q) begin
        pref_q <= 1'b0;
        if (state_q == StData) begin
          tx_q <= reg_data_in;
          miso <= reg_data_in[7];
        end
      end

      if (byte_done_q) begin
        if (byte_cmd_q) begin
          reg_addr <= rx_q[4:0];
          wr_q     <= rx_q[7];
          pref_q   <= ~rx_q[7];
        end else if (wr_q) begin
          reg_write    <= 1'b1;
          reg_data_out <= rx_q;
        end else begin
          pref_q <= 1'b1;
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
          reg_addr <= reg_addr + 5'd1;
`endif
        end
      end

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
      // Writes advance only after the strobe so it carries the current address.
      if (reg_write) begin
        reg_addr <= reg_addr + 5'd1;
      end
`endif
    end
  end

endmodule
